als_spi_responder: RTL and testbench

Synthesizable emulator of the ambient-light-sensor ADC (ADC081S021 on the PmodALS) that answers the `light_sensor` SPI master: on each CS_N-low frame it shifts a captured 8-bit sample out on SDO, MSB first, framed by 3 leading and 5 trailing zeros. It runs on the system clock, oversamples the master's SCLK/CS_N through synchronizers, and serves as loopback target and bench partner for the master (JA0 CS_N, JA2 SDO, JA3 SCLK).

---
 rtl/als_pkg.sv | 14 +
 rtl/als_spi_responder_if.sv | 10 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/als_spi_responder.sv | 126 ++++++++++++
 tb/tb_als_spi_responder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/als_pkg.sv
// Shared frame geometry and FSM encoding for the ALS ADC responder.
package als_pkg;
    localparam int FRAME_BITS  = 16;
    localparam int LEAD_ZEROS  = 3;
    localparam int DATA_BITS   = 8;
    localparam int TRAIL_ZEROS = 5;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
        return {{LEAD_ZEROS{1'b0}}, d, {TRAIL_ZEROS{1'b0}}};
    endfunction
endpackage

// File: rtl/als_spi_responder_if.sv
// SPI pin bundle between the light_sensor master and the ADC responder.
interface als_spi_responder_if;
    logic cs_n;
    logic sclk;
    logic sdo;
    logic sdo_en;

    modport master (output cs_n, sclk, input sdo, sdo_en);
    modport slave  (input cs_n, sclk, output sdo, sdo_en);
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer plus history flop; edge pulses are derived from the
// synchronized level so they are clean single-clk strobes.
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Reset to the idle pin level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;
endmodule

// File: rtl/als_spi_responder.sv
// ADC081S021 emulator: shifts a captured sample out on SDO, framed by 3 leading
// and 5 trailing zeros, one bit per synchronized SCLK falling edge.
module als_spi_responder
    import als_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    als_spi_responder_if.slave     spi,
    input  logic [DATA_BITS-1:0]   sample_in,
    output logic                   frame_done,
    output logic                   frame_abort,
    output logic [15:0]            frame_count
);
    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic unused_sync;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset_n(reset_n), .din(spi.cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .reset_n(reset_n), .din(spi.sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    assign unused_sync = ^{cs_lvl, sclk_lvl, sclk_rise};

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  sdo_q, sdo_d;
    logic                  sdo_en_q, sdo_en_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;
    logic [15:0]           count_q, count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sdo_q     <= 1'b0;
            sdo_en_q  <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sdo_q     <= sdo_d;
            sdo_en_q  <= sdo_en_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sdo_d     = sdo_q;
        sdo_en_d  = sdo_en_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                sdo_d    = 1'b0;
                sdo_en_d = 1'b0;
                if (cs_fall) begin
                    shreg_d   = build_frame(sample_in);
                    bit_cnt_d = '0;
                    sdo_en_d  = 1'b1;
                    sdo_d     = shreg_d[FRAME_BITS-1];
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A CS_N rise in the same clk as an SCLK fall ends the frame;
                // the pending shift is dropped.
                if (cs_rise) begin
                    abort_d  = 1'b1;
                    shreg_d  = '0;
                    sdo_d    = 1'b0;
                    sdo_en_d = 1'b0;
                    state_d  = IDLE;
                end else if (sclk_fall) begin
                    shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                    sdo_d     = shreg_q[FRAME_BITS-2];
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        sdo_d   = 1'b0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                sdo_d = 1'b0;
                if (cs_rise) begin
                    done_d   = 1'b1;
                    count_d  = count_q + 16'd1;
                    shreg_d  = '0;
                    sdo_en_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                sdo_d    = 1'b0;
                sdo_en_d = 1'b0;
            end
        endcase
    end

    assign spi.sdo     = sdo_q;
    assign spi.sdo_en  = sdo_en_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign frame_count = count_q;
endmodule

// File: tb/tb_als_spi_responder.sv
// Directed bench acting as the SPI master; expected frame words are queued at
// frame start and popped once the frame has been captured.
module tb_als_spi_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  sample_in = 8'h00;
    logic        frame_done, frame_abort;
    logic [15:0] frame_count;

    als_spi_responder_if spi();

    als_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .spi(spi), .sample_in(sample_in),
        .frame_done(frame_done), .frame_abort(frame_abort), .frame_count(frame_count)
    );

    always #50 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_pulses = 0;
    int abort_pulses = 0;
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (frame_done)  done_pulses++;
        if (frame_abort) abort_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected capture word: bit (16-k) holds SDO seen on the rise after fall k,
    // so D7..D0 (on SDO after falls 3..10) land in bits 13..6.
    function automatic logic [15:0] exp_word(input logic [7:0] d);
        return {2'b00, d, 6'b000000};
    endfunction

    bit         chg_en = 1'b0;
    logic [7:0] chg_val = 8'h00;

    task automatic frame(input int nfalls, input bit clash, output logic [15:0] cap, output logic en_all);
        cap = '0;
        en_all = 1'b1;
        spi.cs_n = 1'b0;
        wait_clk(2);
        chk("en_lat_before", {31'd0, spi.sdo_en}, 32'd0);
        wait_clk(1);
        chk("en_lat_after", {31'd0, spi.sdo_en}, 32'd1);
        wait_clk(2);
        for (int k = 1; k <= nfalls; k++) begin
            if (clash && k == nfalls) begin
                spi.sclk = 1'b0;
                spi.cs_n = 1'b1;
                wait_clk(6);
                spi.sclk = 1'b1;
                wait_clk(5);
                return;
            end
            spi.sclk = 1'b0;
            if (chg_en && k == 2) sample_in = chg_val;
            wait_clk(5);
            cap[16-k] = spi.sdo;
            en_all = en_all & spi.sdo_en;
            spi.sclk = 1'b1;
            wait_clk(5);
        end
        spi.cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic full_frame(input string tag, input logic [7:0] val);
        logic [15:0] cap, exp;
        logic        en_all;
        int          d0;
        d0 = done_pulses;
        sample_in = val;
        exp_q.push_back(exp_word(val));
        frame(16, 1'b0, cap, en_all);
        exp = exp_q.pop_front();
        chk({tag, "_data"}, {16'd0, cap}, {16'd0, exp});
        chk({tag, "_en"}, {31'd0, en_all}, 32'd1);
        chk({tag, "_done"}, done_pulses - d0, 32'd1);
        chk({tag, "_en_off"}, {31'd0, spi.sdo_en}, 32'd0);
    endtask

    initial begin
        logic [15:0] cap;
        logic        en_all;
        int          d0, a0;
        logic [7:0]  rv;

        spi.cs_n = 1'b1;
        spi.sclk = 1'b1;
        wait_clk(3);
        chk("rst_sdo", {31'd0, spi.sdo}, 32'd0);
        chk("rst_en", {31'd0, spi.sdo_en}, 32'd0);
        chk("rst_cnt", {16'd0, frame_count}, 32'd0);
        chk("rst_pulses", {30'd0, frame_abort, frame_done}, 32'd0);
        reset_n = 1'b1;
        wait_clk(4);

        full_frame("a5", 8'hA5);
        chk("cnt1", {16'd0, frame_count}, 32'd1);

        full_frame("b2b00", 8'h00);
        full_frame("b2bff", 8'hFF);
        chg_en = 1'b1;
        chg_val = 8'h99;
        full_frame("b2b3c", 8'h3C);
        chg_en = 1'b0;
        chk("cnt4", {16'd0, frame_count}, 32'd4);

        // Abort after 9 falls.
        d0 = done_pulses;
        a0 = abort_pulses;
        sample_in = 8'h77;
        frame(9, 1'b0, cap, en_all);
        chk("abort_pulse", abort_pulses - a0, 32'd1);
        chk("abort_nodone", done_pulses - d0, 32'd0);
        chk("abort_cnt", {16'd0, frame_count}, 32'd4);

        // SCLK toggling with CS_N high is ignored.
        for (int i = 0; i < 3; i++) begin
            spi.sclk = 1'b0; wait_clk(5);
            spi.sclk = 1'b1; wait_clk(5);
        end
        chk("idle_sclk_en", {31'd0, spi.sdo_en}, 32'd0);
        full_frame("5a", 8'h5A);
        chk("cnt5", {16'd0, frame_count}, 32'd5);

        // CS_N rise coincident with the 16th fall must abort, not complete.
        d0 = done_pulses;
        a0 = abort_pulses;
        sample_in = 8'h11;
        frame(16, 1'b1, cap, en_all);
        chk("clash_abort", abort_pulses - a0, 32'd1);
        chk("clash_nodone", done_pulses - d0, 32'd0);
        chk("clash_cnt", {16'd0, frame_count}, 32'd5);

        // Reset mid-frame after 6 falls.
        sample_in = 8'h42;
        spi.cs_n = 1'b0;
        wait_clk(5);
        for (int k = 1; k <= 6; k++) begin
            spi.sclk = 1'b0; wait_clk(5);
            spi.sclk = 1'b1; wait_clk(5);
        end
        spi.sclk = 1'b0;
        wait_clk(5);
        #10 reset_n = 1'b0;
        #1;
        chk("mrst_sdo", {31'd0, spi.sdo}, 32'd0);
        chk("mrst_en", {31'd0, spi.sdo_en}, 32'd0);
        chk("mrst_cnt", {16'd0, frame_count}, 32'd0);
        chk("mrst_pulses", {30'd0, frame_abort, frame_done}, 32'd0);
        spi.cs_n = 1'b1;
        spi.sclk = 1'b1;
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(4);
        full_frame("post_rst", 8'hC3);
        chk("post_rst_cnt", {16'd0, frame_count}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            rv = 8'($urandom_range(0, 255));
            full_frame($sformatf("rnd%0d", i), rv);
        end
        chk("final_cnt", {16'd0, frame_count}, 32'd5);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
